// File: rtl/ppl_pkg.sv
// rtl/ppl_pkg.sv - shared types and constants for the pixel sink
//
// Holds the sink state encoding, the default frame geometry and the FIFO
// entry layout shared by ppl_pixel_sink and ppl_sync_fifo.
package ppl_pkg;

  localparam int H_DISP_DEF   = 1280;
  localparam int V_DISP_DEF   = 720;
  localparam int FRAME_PIXELS = H_DISP_DEF * V_DISP_DEF;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    WAIT_VS = 2'd2,
    SWAP    = 2'd3
  } sink_state_t;

  // Pixel count of a frame; this address value doubles as the end marker.
  function automatic int frame_pixels(input int h_disp, input int v_disp);
    return h_disp * v_disp;
  endfunction

  // FIFO entry layout, MSB first: {bank, addr[addr_w], data[data_w]}.
  function automatic int entry_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/ppl_sync_fifo.sv
// rtl/ppl_sync_fifo.sv - first-word-fall-through synchronous FIFO
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write push_data (ignored when full)
//   push_data   : entry to store
//   pop         : drop the head entry (ignored when empty)
//   head        : current head entry, valid whenever empty is low
//   full, empty : registered occupancy flags
module ppl_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_nxt = count - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (PTR_W+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ppl_pixel_sink.sv
// rtl/ppl_pixel_sink.sv - pixel stream sink into a double-buffered frame buffer
//
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   pix_valid      : pipeline presents a pixel
//   pix_addr       : pixel address; H_DISP*V_DISP marks end of frame
//   pix_data       : pixel colour
//   prepare_flag   : pipeline refilling, hold off transfers
//   vs             : frame sync level; rising edge requests a bank swap
//   next_en        : sink ready; transfer on pix_valid && next_en
//   fb_wr_en       : frame buffer write request
//   fb_wr_addr     : {bank, pixel address}
//   fb_wr_data     : write data
//   fb_wr_ready    : frame buffer accepts the write
//   bank_sel       : bank owned by scanout; writes target ~bank_sel
//   frame_done     : one-cycle pulse on bank swap
//   sync_err       : sticky, vs edge arrived before the end marker
//   addr_err       : sticky, out-of-range address received and dropped
module ppl_pixel_sink
  import ppl_pkg::*;
#(
  parameter int H_DISP     = H_DISP_DEF,
  parameter int V_DISP     = V_DISP_DEF,
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic [ADDR_W-1:0] pix_addr,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              prepare_flag,
  input  logic              vs,
  output logic              next_en,
  output logic              fb_wr_en,
  output logic [ADDR_W:0]   fb_wr_addr,
  output logic [DATA_W-1:0] fb_wr_data,
  input  logic              fb_wr_ready,
  output logic              bank_sel,
  output logic              frame_done,
  output logic              sync_err,
  output logic              addr_err
);

  localparam int                ENTRY_W  = entry_w(ADDR_W, DATA_W);
  localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(frame_pixels(H_DISP, V_DISP));

  sink_state_t        state;
  sink_state_t        state_nxt;
  logic               vs_d;
  logic               vs_pend;
  logic               vs_edge;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head;
  logic               accept;
  logic               is_pix;
  logic               is_end;
  logic               is_bad;

  // Ready depends only on registered state, never on fb_wr_ready; it is
  // also forced low while rst is held so every output reads 0 in reset.
  assign next_en = ~rst & ~fifo_full & ~prepare_flag & (state != SWAP);
  assign accept  = pix_valid & next_en;
  assign is_pix  = accept & (pix_addr <  END_ADDR);
  assign is_end  = accept & (pix_addr == END_ADDR);
  assign is_bad  = accept & (pix_addr >  END_ADDR);

  // Target bank is frozen into the entry when the pixel is accepted.
  assign push_entry = {~bank_sel, pix_addr, pix_data};

  ppl_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (is_pix),
    .push_data (push_entry),
    .pop       (fb_wr_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head is gated so the write bus reads 0 (not stale storage) when idle.
  assign fb_wr_en   = ~fifo_empty;
  assign fb_wr_addr = fb_wr_en ? head[ENTRY_W-1:DATA_W] : '0;
  assign fb_wr_data = fb_wr_en ? head[DATA_W-1:0]       : '0;

  assign vs_edge    = vs & ~vs_d;
  assign frame_done = (state == SWAP);

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (is_end)              state_nxt = DRAIN;
      DRAIN:   if (fifo_empty)          state_nxt = WAIT_VS;
      WAIT_VS: if (vs_pend || vs_edge)  state_nxt = SWAP;
      SWAP:                             state_nxt = RUN;
      default:                          state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      vs_d     <= 1'b0;
      vs_pend  <= 1'b0;
      bank_sel <= 1'b0;
      sync_err <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state <= state_nxt;
      vs_d  <= vs;
      // An edge in DRAIN is remembered so it survives the move to WAIT_VS.
      if (state == SWAP) begin
        vs_pend <= 1'b0;
      end else if (state == DRAIN && vs_edge) begin
        vs_pend <= 1'b1;
      end
      if (state == SWAP)           bank_sel <= ~bank_sel;
      if (state == RUN && vs_edge) sync_err <= 1'b1;
      if (is_bad)                  addr_err <= 1'b1;
    end
  end

endmodule
